// File: rtl/mips_alu_32_if.sv
// Request/response bundle for the registered MIPS execute-stage ALU.
// Master drives the request side; slave returns result and flags.
interface mips_alu_32_if #(
  parameter int WORD_SIZE = 32
);
  logic                 start;
  logic [WORD_SIZE-1:0] input_a;
  logic [WORD_SIZE-1:0] input_b;
  logic [3:0]           control;
  logic [WORD_SIZE-1:0] result;
  logic                 zero;
  logic                 cout;
  logic                 err_overflow;
  logic                 err_invalid_control;
  logic                 finished;

  modport master (
    output start, input_a, input_b, control,
    input  result, zero, cout, err_overflow,
    input  err_invalid_control, finished
  );

  modport slave (
    input  start, input_a, input_b, control,
    output result, zero, cout, err_overflow,
    output err_invalid_control, finished
  );
endinterface

// File: rtl/mips_alu_32.sv
// Registered 32-bit MIPS ALU, one-cycle latency, flags registered.
// Define ALU_SLTU_EN to enable the unsigned set-less-than opcode 4'b1000.
module mips_alu_32 #(
  parameter int WORD_SIZE = 32
) (
  input logic            clock,
  input logic            reset_n,
  mips_alu_32_if.slave   bus
);
  localparam int W = WORD_SIZE;

  localparam logic [3:0] CONTROL_AND          = 4'b0000;
  localparam logic [3:0] CONTROL_OR           = 4'b0001;
  localparam logic [3:0] CONTROL_ADD          = 4'b0010;
  localparam logic [3:0] CONTROL_ADD_UNSIGNED = 4'b0011;
  localparam logic [3:0] CONTROL_SUB          = 4'b0110;
  localparam logic [3:0] CONTROL_SLT          = 4'b0111;
  localparam logic [3:0] CONTROL_NOR          = 4'b1100;
`ifdef ALU_SLTU_EN
  localparam logic [3:0] CONTROL_SLTU         = 4'b1000;
`endif

  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   ctrl;

  assign a    = bus.input_a;
  assign b    = bus.input_b;
  assign ctrl = bus.control;

  logic op_and;
  logic op_or;
  logic op_nor;
  logic op_add;
  logic op_addu;
  logic op_sub;
  logic op_slt;
  logic op_sltu;

  assign op_and  = (ctrl == CONTROL_AND);
  assign op_or   = (ctrl == CONTROL_OR);
  assign op_nor  = (ctrl == CONTROL_NOR);
  assign op_add  = (ctrl == CONTROL_ADD);
  assign op_addu = (ctrl == CONTROL_ADD_UNSIGNED);
  assign op_sub  = (ctrl == CONTROL_SUB);
  assign op_slt  = (ctrl == CONTROL_SLT);
`ifdef ALU_SLTU_EN
  assign op_sltu = (ctrl == CONTROL_SLTU);
`else
  assign op_sltu = 1'b0;
`endif

  logic [W:0] sum;
  logic [W:0] diff;
  logic       add_ovf;
  logic       sub_ovf;
  logic       slt_lt;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);

  assign add_ovf = (a[W-1] == b[W-1])
                && (sum[W-1] != a[W-1]);
  assign sub_ovf = (a[W-1] != b[W-1])
                && (diff[W-1] != a[W-1]);
  // Sign of a-b corrected by overflow gives a true signed compare
  assign slt_lt  = diff[W-1] ^ sub_ovf;

  logic [W-1:0] res_d;
  logic         cout_d;
  logic         ovf_d;
  logic         inv_d;

  always_comb begin
    res_d  = '0;
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    inv_d  = 1'b0;
    unique case (1'b1)
      op_and:  res_d = a & b;
      op_or:   res_d = a | b;
      op_nor:  res_d = ~(a | b);
      op_add: begin
        res_d  = sum[W-1:0];
        cout_d = sum[W];
        ovf_d  = add_ovf;
      end
      op_addu: begin
        res_d  = sum[W-1:0];
        cout_d = sum[W];
      end
      op_sub: begin
        res_d  = diff[W-1:0];
        cout_d = diff[W];
        ovf_d  = sub_ovf;
      end
      op_slt:  res_d = {{(W-1){1'b0}}, slt_lt};
      op_sltu: res_d = {{(W-1){1'b0}}, ~diff[W]};
      default: inv_d = 1'b1;
    endcase
  end

  logic [W-1:0] result_q;
  logic         zero_q;
  logic         cout_q;
  logic         ovf_q;
  logic         inv_q;
  logic         fin_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      fin_q <= bus.start;
      if (bus.start) begin
        result_q <= res_d;
        zero_q   <= (res_d == '0);
        cout_q   <= cout_d;
        ovf_q    <= ovf_d;
        inv_q    <= inv_d;
      end
    end
  end

  assign bus.result              = result_q;
  assign bus.zero                = zero_q;
  assign bus.cout                = cout_q;
  assign bus.err_overflow        = ovf_q;
  assign bus.err_invalid_control = inv_q;
  assign bus.finished            = fin_q;
endmodule

// File: tb/tb_mips_alu_32.sv
// Scoreboard bench for mips_alu_32: driver queues expected
// responses, monitor pops and compares whenever finished is high.
module tb_mips_alu_32;
  logic clk;
  logic rst_n;

  mips_alu_32_if #(.WORD_SIZE(32)) bus ();

  mips_alu_32 #(.WORD_SIZE(32)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        o;
    logic        inv;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;
  int pushed = 0;
  int popped = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, pending=%0d", q.size());
    $fatal(1, "timeout");
  end

  // Monitor: sample 1 time unit after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && bus.finished) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_finished: got result=%h, no request queued",
                   bus.result);
        end else begin
          e = q.pop_front();
          popped++;
          if (bus.result !== e.res || bus.zero !== e.z ||
              bus.cout !== e.c || bus.err_overflow !== e.o ||
              bus.err_invalid_control !== e.inv) begin
            fails++;
            $display("FAIL %s: got res=%h z=%b c=%b o=%b inv=%b, want res=%h z=%b c=%b o=%b inv=%b",
                     e.name, bus.result, bus.zero, bus.cout,
                     bus.err_overflow, bus.err_invalid_control,
                     e.res, e.z, e.c, e.o, e.inv);
          end
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic z,
                       input logic co, input logic o, input logic inv);
    exp_t e;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.control = c;
    bus.input_a = a;
    bus.input_b = b;
    e.name = nm; e.res = r; e.z = z; e.c = co; e.o = o; e.inv = inv;
    q.push_back(e);
    pushed++;
  endtask

  task automatic check_all(input string nm, input logic [31:0] r,
                           input logic z, input logic co, input logic o,
                           input logic inv, input logic fin);
    checks++;
    if (bus.result !== r || bus.zero !== z || bus.cout !== co ||
        bus.err_overflow !== o || bus.err_invalid_control !== inv ||
        bus.finished !== fin) begin
      fails++;
      $display("FAIL %s: got res=%h z=%b c=%b o=%b inv=%b fin=%b, want res=%h z=%b c=%b o=%b inv=%b fin=%b",
               nm, bus.result, bus.zero, bus.cout, bus.err_overflow,
               bus.err_invalid_control, bus.finished,
               r, z, co, o, inv, fin);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.control = 4'h0;
    bus.input_a = 32'h0;
    bus.input_b = 32'h0;
    #3;
    check_all("reset_state", 32'h0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream, start held high
    issue("and_zero", 4'b0000, 32'h0000FF00, 32'h000000FF, 32'h0, 1, 0, 0, 0);
    issue("or_ones",  4'b0001, 32'hFFFFFFFF, 32'h0000000F, 32'hFFFFFFFF, 0, 0, 0, 0);
    issue("nor",      4'b1100, 32'h1, 32'h1, 32'hFFFFFFFE, 0, 0, 0, 0);
    issue("addu_wrap", 4'b0011, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 1, 0, 0);
    issue("addu_1234", 4'b0011, 32'd1234, 32'd4321, 32'd5555, 0, 0, 0, 0);
    issue("add_posovf", 4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 1, 0);
    issue("add_negovf", 4'b0010, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 0, 1, 1, 0);
    issue("add_m1p1", 4'b0010, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 1, 0, 0);
    issue("sub_borrow", 4'b0110, 32'd100, 32'd101, 32'hFFFFFFFF, 0, 0, 0, 0);
    issue("sub_minovf", 4'b0110, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 1, 1, 0);
    issue("sub_maxovf", 4'b0110, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1, 0);
    issue("slt_neg", 4'b0111, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 0);
    issue("slt_0_m1", 4'b0111, 32'h0, 32'hFFFFFFFF, 32'h0, 1, 0, 0, 0);
    issue("slt_eq", 4'b0111, 32'h1, 32'h1, 32'h0, 1, 0, 0, 0);
    issue("slt_ovfcorr", 4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'h1, 0, 0, 0, 0);
    issue("invalid_f", 4'hF, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1, 0, 0, 1);
`ifdef ALU_SLTU_EN
    issue("sltu", 4'b1000, 32'h1, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 0);
`else
    issue("op8_invalid", 4'b1000, 32'h1, 32'hFFFFFFFF, 32'h0, 1, 0, 0, 1);
`endif

    // Hold: start low, operands changing, outputs must not move
    issue("hold_src", 4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 1, 0);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.control = 4'b0000;
    bus.input_a = 32'h0;
    bus.input_b = 32'h0;
    @(posedge clk);
    #2;
    check_all("hold_1", 32'h80000000, 0, 0, 1, 0, 0);
    @(negedge clk);
    bus.control = 4'hF;
    @(posedge clk);
    #2;
    check_all("hold_2", 32'h80000000, 0, 0, 1, 0, 0);

    // Asynchronous reset right after a capture
    issue("pre_reset", 4'b0001, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk);
    #2;
    check_all("post_reset_idle", 32'h0, 0, 0, 0, 0, 0);

    issue("after_reset", 4'b0010, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    checks++;
    if (q.size() != 0 || popped != pushed) begin
      fails++;
      $display("FAIL drain: got %0d responses, want %0d (pending %0d)",
               popped, pushed, q.size());
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
